// File: rtl/det_stat_ctrl_pkg.sv
// Shared types and constants for the detector trial sequencer.
// Window bounds are bit positions counted from 1 within a trial.
package det_stat_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, ACCUM, DONE} state_t;

   localparam int NUM_DET = 3;
   localparam int DET55   = 0;
   localparam int DET59   = 1;
   localparam int DET472  = 2;

   localparam int BITS_W = 4;

   localparam logic [BITS_W-1:0] WIN_LO [NUM_DET] = '{4'd5, 4'd5, 4'd4};
   localparam logic [BITS_W-1:0] WIN_HI [NUM_DET] = '{4'd5, 4'd9, 4'd7};

   // A window may not extend past the last bit of the trial.
   function automatic logic [BITS_W-1:0] clip_hi(input logic [BITS_W-1:0] hi, input int win_len);
      return (int'(hi) > win_len) ? BITS_W'(win_len) : hi;
   endfunction

endpackage

// File: rtl/det_stat_ctrl_if.sv
// Control/statistics bundle between the sequencer and its host.
// The slave modport is the sequencer side, the master modport the host side.
interface det_stat_ctrl_if #(
   parameter int TRIAL_W = 16,
   parameter int CNT_W   = 16
);
   logic               start;
   logic [TRIAL_W-1:0] num_trials;
   logic               bit_valid;
   logic [2:0]         hit;
   logic               det_clr;
   logic               busy;
   logic               done;
   logic [TRIAL_W-1:0] trial_cnt;
   logic [CNT_W-1:0]   cnt55;
   logic [CNT_W-1:0]   cnt59;
   logic [CNT_W-1:0]   cnt472;

   modport master (
      output start, num_trials, bit_valid, hit,
      input  det_clr, busy, done, trial_cnt, cnt55, cnt59, cnt472
   );

   modport slave (
      input  start, num_trials, bit_valid, hit,
      output det_clr, busy, done, trial_cnt, cnt55, cnt59, cnt472
   );
endinterface

// File: rtl/det_stat_ctrl_hit_latch.sv
// One-shot flag per detector: set by a hit whose bit position lies in [lo, hi],
// held until the next trial clear.
module det_hit_latch
   import det_stat_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [BITS_W-1:0] bits_seen,
   input  logic [BITS_W-1:0] lo,
   input  logic [BITS_W-1:0] hi,
   input  logic              hit,
   output logic              flag
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag <= 1'b0;
      end else if (clr) begin
         flag <= 1'b0;
      end else if (hit && (bits_seen >= lo) && (bits_seen <= hi)) begin
         flag <= 1'b1;
      end
   end

endmodule

// File: rtl/det_stat_ctrl.sv
// Trial sequencer and per-detector hit accumulators for the pattern detectors.
// Hit positions include the bit consumed in the same cycle, so a trial spends WIN_LEN valid cycles in RUN.
module det_stat_ctrl
   import det_stat_pkg::*;
#(
   parameter int WIN_LEN = 9,
   parameter int TRIAL_W = 16,
   parameter int CNT_W   = 16
) (
   input  logic          clk,
   input  logic          reset,
   det_stat_ctrl_if.slave bus
);

   localparam logic [BITS_W-1:0] WIN_END = BITS_W'(WIN_LEN);

   state_t             state;
   state_t             next_state;
   logic [TRIAL_W-1:0] trials_lat;
   logic [TRIAL_W-1:0] trial_cnt;
   logic [TRIAL_W-1:0] trial_next;
   logic [CNT_W-1:0]   cnt [NUM_DET];
   logic [BITS_W-1:0]  bits_seen;
   logic [BITS_W-1:0]  bits_now;
   logic [NUM_DET-1:0] latched;
   logic               start_ok;
   logic               det_clr_q;
   logic               busy_q;
   logic               done_q;

   assign start_ok   = bus.start && ((state == IDLE) || (state == DONE));
   assign bits_now   = bits_seen + BITS_W'(bus.bit_valid);
   assign trial_next = trial_cnt + TRIAL_W'(1);

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start_ok) next_state = (bus.num_trials == '0) ? DONE : CLEAR;
         CLEAR:      next_state = RUN;
         RUN:        if (bits_now >= WIN_END) next_state = ACCUM;
         ACCUM:      next_state = (trial_next == trials_lat) ? DONE : CLEAR;
         default:    next_state = IDLE;
      endcase
   end

   // Status outputs are decoded from next_state so they leave a flop aligned with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         det_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= next_state;
         det_clr_q <= (next_state == CLEAR);
         busy_q    <= (next_state == CLEAR) || (next_state == RUN) || (next_state == ACCUM);
         done_q    <= (next_state == DONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trials_lat <= '0;
         trial_cnt  <= '0;
         bits_seen  <= '0;
         for (int i = 0; i < NUM_DET; i++) cnt[i] <= '0;
      end else begin
         if (start_ok) begin
            trials_lat <= bus.num_trials;
            trial_cnt  <= '0;
            for (int i = 0; i < NUM_DET; i++) cnt[i] <= '0;
         end else if (state == ACCUM) begin
            trial_cnt <= trial_next;
            for (int i = 0; i < NUM_DET; i++) begin
               if (latched[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
         if (state == CLEAR) begin
            bits_seen <= '0;
         end else if ((state == RUN) && bus.bit_valid) begin
            bits_seen <= bits_now;
         end
      end
   end

   for (genvar g = 0; g < NUM_DET; g++) begin : g_latch
      localparam logic [BITS_W-1:0] HI_EFF = clip_hi(WIN_HI[g], WIN_LEN);
      det_hit_latch u_latch (
         .clk       (clk),
         .reset     (reset),
         .clr       (state == CLEAR),
         .bits_seen (bits_now),
         .lo        (WIN_LO[g]),
         .hi        (HI_EFF),
         .hit       (bus.hit[g] && (state == RUN)),
         .flag      (latched[g])
      );
   end

   assign bus.det_clr   = det_clr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.trial_cnt = trial_cnt;
   assign bus.cnt55     = cnt[DET55];
   assign bus.cnt59     = cnt[DET59];
   assign bus.cnt472    = cnt[DET472];

endmodule

// File: tb/tb_det_stat_ctrl.sv
// Randomized bench for det_stat_ctrl: drives whole trials cycle by cycle and predicts
// hit counts from bit positions and detector windows, for a 16-bit and a 3-bit counter build.
module tb_det_stat_ctrl;

   localparam int WIN_LEN = 9;
   localparam int TRIAL_W = 16;
   localparam int CNT_W   = 16;
   localparam int SMALL_W = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   det_stat_ctrl_if #(.TRIAL_W(TRIAL_W), .CNT_W(CNT_W))   bus ();
   det_stat_ctrl_if #(.TRIAL_W(TRIAL_W), .CNT_W(SMALL_W)) sbus ();

   assign sbus.start      = bus.start;
   assign sbus.num_trials = bus.num_trials;
   assign sbus.bit_valid  = bus.bit_valid;
   assign sbus.hit        = bus.hit;

   det_stat_ctrl #(.WIN_LEN(WIN_LEN), .TRIAL_W(TRIAL_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   det_stat_ctrl #(.WIN_LEN(WIN_LEN), .TRIAL_W(TRIAL_W), .CNT_W(SMALL_W)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   int checks = 0;
   int fails  = 0;
   int lo_tab [3] = '{5, 5, 4};
   int hi_tab [3] = '{5, 9, 7};
   int exp_cnt [3];
   int exp_trials;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic int win_hi(input int i);
      return (hi_tab[i] > WIN_LEN) ? WIN_LEN : hi_tab[i];
   endfunction

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_trials"},  int'(bus.trial_cnt),  exp_trials);
      checkOutput({tag, "_c55"},     int'(bus.cnt55),      sat(exp_cnt[0], CNT_W));
      checkOutput({tag, "_c59"},     int'(bus.cnt59),      sat(exp_cnt[1], CNT_W));
      checkOutput({tag, "_c472"},    int'(bus.cnt472),     sat(exp_cnt[2], CNT_W));
      checkOutput({tag, "_s_trials"}, int'(sbus.trial_cnt), exp_trials);
      checkOutput({tag, "_s_c55"},   int'(sbus.cnt55),     sat(exp_cnt[0], SMALL_W));
      checkOutput({tag, "_s_c59"},   int'(sbus.cnt59),     sat(exp_cnt[1], SMALL_W));
      checkOutput({tag, "_s_c472"},  int'(sbus.cnt472),    sat(exp_cnt[2], SMALL_W));
   endtask

   task automatic driveNoise();
      bus.bit_valid = 1'($urandom_range(0, 1));
      bus.hit       = 3'($urandom_range(0, 7));
   endtask

   // Stimulus for one RUN cycle, chosen by test mode from the bit position it produces.
   task automatic pick(input int mode, input int c, input int valid,
                       output logic bv, output logic [2:0] h);
      int pos;
      case (mode)
         1, 3:    bv = 1'b1;
         2:       bv = 1'($urandom_range(0, 1));
         4:       bv = ((c % 2) == 1);
         default: bv = ($urandom_range(0, 3) != 0);
      endcase
      if (c > 60) bv = 1'b1;
      pos = valid + int'(bv);
      h = 3'b000;
      case (mode)
         1, 4: h = 3'b111;
         2: begin
            h[0] = (pos == 4) || (pos == 6);
            h[1] = (pos == 10);
            h[2] = (pos == 3);
         end
         3: h[1] = (pos >= 5) && (pos <= 9);
         default: for (int i = 0; i < 3; i++) h[i] = ($urandom_range(0, 3) == 0);
      endcase
   endtask

   task automatic applyStimulus(input int n, input int mode, input int abort_trial, input bit stray_start);
      int valid;
      int c;
      int pos;
      bit got [3];
      logic bv;
      logic [2:0] h;

      exp_trials = 0;
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;

      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.num_trials = TRIAL_W'(n);
      driveNoise();
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.num_trials = TRIAL_W'($urandom_range(1, 200));

      if (n == 0) begin
         driveNoise();
         @(negedge clk);
         checkOutput("zero_busy", int'(bus.busy), 0);
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("zero_busy2", int'(bus.busy), 0);
         checkOutput("zero_done", int'(bus.done), 1);
         checkCounters("zero");
         return;
      end

      for (int t = 0; t < n; t++) begin
         driveNoise();
         @(negedge clk);
         checkOutput("clr_pulse", int'(bus.det_clr), 1);
         checkOutput("clr_busy",  int'(bus.busy), 1);
         checkOutput("clr_done",  int'(bus.done), 0);
         @(posedge clk); #1;

         valid = 0;
         c = 0;
         for (int i = 0; i < 3; i++) got[i] = 1'b0;
         while (valid < WIN_LEN) begin
            pick(mode, c, valid, bv, h);
            bus.bit_valid = bv;
            bus.hit       = h;
            if (stray_start && (t == 0) && (c == 2)) begin
               bus.start      = 1'b1;
               bus.num_trials = TRIAL_W'(99);
            end else begin
               bus.start = 1'b0;
            end
            pos = valid + int'(bv);
            for (int i = 0; i < 3; i++) begin
               if (h[i] && (pos >= lo_tab[i]) && (pos <= win_hi(i))) got[i] = 1'b1;
            end
            valid = pos;

            if ((t == abort_trial) && (c == 3)) begin
               reset = 1'b1;
               #2;
               checkOutput("arst_busy",   int'(bus.busy), 0);
               checkOutput("arst_clr",    int'(bus.det_clr), 0);
               checkOutput("arst_trials", int'(bus.trial_cnt), 0);
               checkOutput("arst_c55",    int'(bus.cnt55), 0);
               checkOutput("arst_c59",    int'(bus.cnt59), 0);
               checkOutput("arst_c472",   int'(bus.cnt472), 0);
               bus.start      = 1'b1;
               bus.num_trials = TRIAL_W'(5);
               @(posedge clk); #1;
               bus.start = 1'b0;
               reset     = 1'b0;
               @(negedge clk);
               checkOutput("rst_wins_busy", int'(bus.busy), 0);
               checkOutput("rst_wins_done", int'(bus.done), 0);
               return;
            end

            @(negedge clk);
            checkOutput("run_clr",  int'(bus.det_clr), 0);
            checkOutput("run_busy", int'(bus.busy), 1);
            @(posedge clk); #1;
            c++;
         end
         bus.start = 1'b0;

         driveNoise();
         @(negedge clk);
         checkOutput("acc_busy", int'(bus.busy), 1);
         checkOutput("acc_clr",  int'(bus.det_clr), 0);
         for (int i = 0; i < 3; i++) exp_cnt[i] += int'(got[i]);
         exp_trials++;
         @(posedge clk); #1;
      end

      driveNoise();
      @(negedge clk);
      checkOutput("end_done", int'(bus.done), 1);
      checkOutput("end_busy", int'(bus.busy), 0);
      checkOutput("end_clr",  int'(bus.det_clr), 0);
      checkCounters("end");
   endtask

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.num_trials = '0;
      bus.bit_valid  = 1'b0;
      bus.hit        = 3'b000;
      exp_trials     = 0;
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;

      #12;
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_done", int'(bus.done), 0);
      checkOutput("rst_clr",  int'(bus.det_clr), 0);
      checkCounters("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", int'(bus.busy), 0);

      applyStimulus(0, 0, -1, 1'b0);
      applyStimulus(4, 1, -1, 1'b0);
      applyStimulus(1, 2, -1, 1'b0);
      applyStimulus(2, 3, -1, 1'b0);
      applyStimulus(10, 1, -1, 1'b0);
      applyStimulus(5, 0, 2, 1'b0);
      applyStimulus(1, 0, -1, 1'b0);
      applyStimulus(3, 0, -1, 1'b1);
      applyStimulus(1, 4, -1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus($urandom_range(1, 6), 0, -1, 1'b0);
      end
      applyStimulus(0, 0, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
